// File: rtl/add64_pipe2.sv
// Two-stage pipelined N-bit adder with valid/ready handshakes on both sides
// and a saturating counter of delivered results that carried out.
module add64_pipe2 #(
   parameter int unsigned N = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         carry_in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] S,
   output logic         carry_out,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic         clear_stats,
   output logic [15:0]  ovf_count
);

   localparam int unsigned LW = N / 2;
   localparam int unsigned HW = N - LW;
   localparam int unsigned LSW = LW + 1;
   localparam int unsigned HSW = HW + 1;
   localparam logic [15:0] OVF_MAX = 16'hFFFF;

   // stage 1 state
   logic          s1_valid_q, s1_valid_d;
   logic [LW-1:0] low_sum_q, low_sum_d;
   logic          mid_carry_q, mid_carry_d;
   logic [HW-1:0] a_hi_q, a_hi_d;
   logic [HW-1:0] b_hi_q, b_hi_d;

   // stage 2 state
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  s_q, s_d;
   logic          carry_out_q, carry_out_d;
   logic [15:0]   ovf_count_q, ovf_count_d;

   logic           accept_c;
   logic           deliver_c;
   logic           s2_load_c;
   logic [LSW-1:0] low_full_c;
   logic [HSW-1:0] hi_full_c;

   // Stage 2 refills when its slot is empty or being drained this cycle.
   assign s2_load_c = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready  = rst_n & (~s1_valid_q | s2_load_c);
   assign accept_c  = in_valid & in_ready;
   assign deliver_c = out_valid_q & out_ready;

   assign low_full_c = {1'b0, A[LW-1:0]} + {1'b0, B[LW-1:0]} + LSW'(carry_in);
   assign hi_full_c  = {1'b0, a_hi_q} + {1'b0, b_hi_q} + HSW'(mid_carry_q);

   always_comb begin
      s1_valid_d  = s1_valid_q;
      low_sum_d   = low_sum_q;
      mid_carry_d = mid_carry_q;
      a_hi_d      = a_hi_q;
      b_hi_d      = b_hi_q;
      out_valid_d = out_valid_q;
      s_d         = s_q;
      carry_out_d = carry_out_q;
      ovf_count_d = ovf_count_q;

      if (accept_c) begin
         s1_valid_d  = 1'b1;
         low_sum_d   = low_full_c[LW-1:0];
         mid_carry_d = low_full_c[LW];
         a_hi_d      = A[N-1:LW];
         b_hi_d      = B[N-1:LW];
      end else if (s2_load_c) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load_c) begin
         out_valid_d = 1'b1;
         s_d         = {hi_full_c[HW-1:0], low_sum_q};
         carry_out_d = hi_full_c[HW];
      end else if (deliver_c) begin
         out_valid_d = 1'b0;
      end

      // Clear wins over a coincident increment.
      if (clear_stats) begin
         ovf_count_d = 16'd0;
      end else if (deliver_c && carry_out_q && (ovf_count_q != OVF_MAX)) begin
         ovf_count_d = ovf_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         low_sum_q   <= '0;
         mid_carry_q <= 1'b0;
         a_hi_q      <= '0;
         b_hi_q      <= '0;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         carry_out_q <= 1'b0;
         ovf_count_q <= 16'd0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         low_sum_q   <= low_sum_d;
         mid_carry_q <= mid_carry_d;
         a_hi_q      <= a_hi_d;
         b_hi_q      <= b_hi_d;
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         carry_out_q <= carry_out_d;
         ovf_count_q <= ovf_count_d;
      end
   end

   assign S         = s_q;
   assign carry_out = carry_out_q;
   assign out_valid = out_valid_q;
   assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_add64_pipe2.sv
// Directed bench for add64_pipe2: reset, carry propagation, streaming,
// backpressure, overflow counter saturation/clear and mid-flight reset.
module tb_add64_pipe2;

   localparam int unsigned N = 64;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] a, b;
   logic         cin;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] s;
   logic         cout;
   logic         out_valid;
   logic         out_ready;
   logic         clear_stats;
   logic [15:0]  ovf_count;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_acc    = 0;
   logic         acc;
   logic [N:0]   pending_exp;
   logic [N:0]   exp_q[$];
   logic [15:0]  ovf_exp = 16'd0;

   always #5 clk = ~clk;

   add64_pipe2 #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (a),
      .B          (b),
      .carry_in   (cin),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .S          (s),
      .carry_out  (cout),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .clear_stats(clear_stats),
      .ovf_count  (ovf_count)
   );

   task automatic check_eq(input string tag, input logic [N:0] obs, input logic [N:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv,
                        input logic [N:0] ev);
      a = av; b = bv; cin = cv; pending_exp = ev;
   endtask

   // One clock: record handshakes just before the edge, then step past it.
   task automatic cycle();
      logic [N:0] e;
      logic       inc;
      #1;
      acc = in_valid & in_ready;
      inc = 1'b0;
      if (acc) begin
         exp_q.push_back(pending_exp);
         n_acc++;
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("no_stale", (N+1)'(out_valid), '0);
         end else begin
            e = exp_q.pop_front();
            check_eq("result", {cout, s}, e);
            inc = e[N];
         end
      end
      if (rst_n && clear_stats) ovf_exp = 16'd0;
      else if (rst_n && inc && ovf_exp != 16'hFFFF) ovf_exp = ovf_exp + 16'd1;
      @(posedge clk);
      #1;
   endtask

   logic [N-1:0] dir_a [6];
   logic [N-1:0] dir_b [6];
   logic         dir_c [6];
   logic [N:0]   dir_e [6];
   logic [N-1:0] ra, rb;
   logic         rc;
   int           idx;
   int           acc0;

   initial begin
      dir_a[0] = 64'd1;                  dir_b[0] = 64'd1;                  dir_c[0] = 1'b0;
      dir_e[0] = 65'd2;
      dir_a[1] = 64'h0000_0000_FFFF_FFFF; dir_b[1] = 64'd1;                  dir_c[1] = 1'b0;
      dir_e[1] = 65'h0_0000_0001_0000_0000;
      dir_a[2] = 64'h7FFF_FFFF_FFFF_FFFF; dir_b[2] = 64'd1;                  dir_c[2] = 1'b0;
      dir_e[2] = 65'h0_8000_0000_0000_0000;
      dir_a[3] = 64'h8000_0000_0000_0000; dir_b[3] = 64'h8000_0000_0000_0000; dir_c[3] = 1'b0;
      dir_e[3] = 65'h1_0000_0000_0000_0000;
      dir_a[4] = 64'hFFFF_FFFF_FFFF_FFFF; dir_b[4] = 64'hFFFF_FFFF_FFFF_FFFF; dir_c[4] = 1'b1;
      dir_e[4] = 65'h1_FFFF_FFFF_FFFF_FFFF;
      dir_a[5] = 64'h0123_4567_89AB_CDEF; dir_b[5] = 64'hFEDC_BA98_7654_3210; dir_c[5] = 1'b1;
      dir_e[5] = 65'h1_0000_0000_0000_0000;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
      drive('0, '0, 1'b0, '0);

      // reset
      cycle();
      cycle();
      check_eq("rst_in_ready", (N+1)'(in_ready), 65'd0);
      rst_n = 1'b1;
      #1;
      check_eq("rel_in_ready", (N+1)'(in_ready), 65'd1);
      check_eq("rel_out_valid", (N+1)'(out_valid), 65'd0);
      check_eq("rel_sum", {cout, s}, 65'd0);
      check_eq("rel_ovf", (N+1)'(ovf_count), 65'd0);

      // mid-carry propagation and latency
      in_valid = 1'b1;
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 65'h1_0000_0000_0000_0000);
      cycle();
      in_valid = 1'b0;
      cycle();
      check_eq("mc_out_valid", (N+1)'(out_valid), 65'd1);
      check_eq("mc_sum", {cout, s}, 65'h1_0000_0000_0000_0000);
      cycle();
      check_eq("mc_ovf", (N+1)'(ovf_count), 65'd1);

      // directed table, back-to-back
      acc0 = n_acc;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(dir_a[i], dir_b[i], dir_c[i], dir_e[i]);
         cycle();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) cycle();
      check_eq("dir_accepts", (N+1)'(n_acc - acc0), 65'd6);
      check_eq("dir_drained", (N+1)'(exp_q.size()), 65'd0);
      check_eq("dir_ovf", (N+1)'(ovf_count), 65'd4);

      // random stream, one per cycle
      acc0 = n_acc;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 1'($urandom);
         drive(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + (N+1)'(rc));
         cycle();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) cycle();
      check_eq("rnd_accepts", (N+1)'(n_acc - acc0), 65'd50);
      check_eq("rnd_drained", (N+1)'(exp_q.size()), 65'd0);
      check_eq("rnd_ovf", (N+1)'(ovf_count), (N+1)'(ovf_exp));

      // backpressure: only two sets fit
      out_ready = 1'b0;
      in_valid = 1'b1;
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         drive(64'd10 * 64'(idx + 1), 64'd5, 1'b0, 65'd10 * 65'(idx + 1) + 65'd5);
         cycle();
         if (acc) idx++;
         if (i >= 2) check_eq("bp_hold", {cout, s}, 65'd15);
      end
      check_eq("bp_accepts", (N+1)'(idx), 65'd2);
      check_eq("bp_in_ready", (N+1)'(in_ready), 65'd0);
      check_eq("bp_out_valid", (N+1)'(out_valid), 65'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) cycle();
      check_eq("bp_drained", (N+1)'(exp_q.size()), 65'd0);

      // drive ovf_count up to saturation
      in_valid = 1'b1;
      drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 65'h1_0000_0000_0000_0000);
      for (int k = 0; k < 70000 && (int'(ovf_exp) + exp_q.size()) < 32'hFFFE; k++) cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
      check_eq("ovf_fffe", (N+1)'(ovf_count), 65'h0FFFE);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
      check_eq("ovf_sat", (N+1)'(ovf_count), 65'h0FFFF);

      // clear coincident with a carry-out delivery
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      check_eq("clr_pending", {out_valid, cout}, 65'd3);
      clear_stats = 1'b1;
      cycle();
      clear_stats = 1'b0;
      check_eq("clr_ovf", (N+1)'(ovf_count), 65'd0);

      // reset with two sets in flight
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(64'd7, 64'd8, 1'b0, 65'd15);
      cycle();
      drive(64'd9, 64'd9, 1'b1, 65'd19);
      cycle();
      in_valid = 1'b0;
      check_eq("mr_accepts", (N+1)'(exp_q.size()), 65'd2);
      rst_n = 1'b0;
      cycle();
      check_eq("mr_in_ready", (N+1)'(in_ready), 65'd0);
      exp_q.delete();
      ovf_exp = 16'd0;
      rst_n = 1'b1;
      #1;
      check_eq("mr_out_valid", (N+1)'(out_valid), 65'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) cycle();
      check_eq("mr_no_stale", (N+1)'(out_valid), 65'd0);
      check_eq("mr_ovf", (N+1)'(ovf_count), 65'd0);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
